// File: rtl/i2c_target_resp.sv
`timescale 1ns/1ps
// i2c_target_resp: I2C target that ACKs its own address, hands received write
// bytes out on a valid pulse, and fetches read bytes on demand, stretching SCL
// until the byte source responds.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   scl_i, sda_i          bus lines as seen on the wire (asynchronous)
//   scl_o, sda_o          open-drain drives (0 pulls low, 1 releases)
//   wr_valid_o, wr_data_o received write byte, one-cycle pulse
//   rd_req_o              one-cycle request for the next read byte
//   rd_valid_i, rd_data_i read byte handshake from the byte source
//   start_o, stop_o       one-cycle pulses on bus START / STOP
//   busy_o                high from an address match until STOP
module i2c_target_resp #(
    parameter int unsigned                I2C_ADDR_WIDTH = 7,
    parameter int unsigned                I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]  TARGET_ADDR    = 7'h22
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      wr_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      rd_req_o,
    input  logic                      rd_valid_i,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o
);

    localparam int unsigned AW = I2C_ADDR_WIDTH;
    localparam int unsigned DW = I2C_DATA_WIDTH;
    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_FETCH,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    // Synchronizer stages plus one history flop per line.
    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    // Bus events; START/STOP require SCL high on both compared samples.
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    state_t          state, state_n;
    logic [CW-1:0]   bit_cnt, bit_cnt_n;
    logic [DW-1:0]   shreg, shreg_n;
    logic            rw, rw_n;
    // ACK states: ACK low is being driven. RD_FETCH: request already issued.
    logic            phase, phase_n;
    logic            scl_n, sda_n, wr_valid_n, rd_req_n, start_n, stop_n, busy_n;
    logic [DW-1:0]   wr_data_n;

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw         <= 1'b0;
            phase      <= 1'b0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
            wr_valid_o <= 1'b0;
            wr_data_o  <= '0;
            rd_req_o   <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            rw         <= rw_n;
            phase      <= phase_n;
            scl_o      <= scl_n;
            sda_o      <= sda_n;
            wr_valid_o <= wr_valid_n;
            wr_data_o  <= wr_data_n;
            rd_req_o   <= rd_req_n;
            start_o    <= start_n;
            stop_o     <= stop_n;
            busy_o     <= busy_n;
        end
    end

    // Next-state and next-output logic; STOP and START override every state.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rw_n       = rw;
        phase_n    = phase;
        scl_n      = scl_o;
        sda_n      = sda_o;
        wr_valid_n = 1'b0;
        wr_data_n  = wr_data_o;
        rd_req_n   = 1'b0;
        start_n    = start_det;
        stop_n     = stop_det;
        busy_n     = busy_o;

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            phase_n   = 1'b0;
            scl_n     = 1'b1;
            sda_n     = 1'b1;
            busy_n    = 1'b0;
        end else if (start_det) begin
            // Any partial byte is dropped here without a valid pulse.
            state_n   = ADDR;
            bit_cnt_n = '0;
            shreg_n   = '0;
            phase_n   = 1'b0;
            scl_n     = 1'b1;
            sda_n     = 1'b1;
        end else begin
            unique case (state)
                IDLE, IGNORE: begin
                    scl_n = 1'b1;
                    sda_n = 1'b1;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[DW-2:0], sda_s2};
                        bit_cnt_n = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(AW)) begin
                            // Address bits already in shreg; this bit is R/W.
                            rw_n      = sda_s2;
                            bit_cnt_n = '0;
                            phase_n   = 1'b0;
                            if (shreg[AW-1:0] == TARGET_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end

                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_n   = 1'b0;
                            phase_n = 1'b1;
                        end else begin
                            sda_n     = 1'b1;
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && rw) begin
                                // This falling edge starts the first read bit.
                                state_n  = RD_FETCH;
                                rd_req_n = 1'b1;
                                scl_n    = 1'b0;
                                phase_n  = 1'b1;
                            end else begin
                                state_n = WR_DATA;
                                phase_n = 1'b0;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[DW-2:0], sda_s2};
                        bit_cnt_n = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DW - 1)) begin
                            wr_data_n  = {shreg[DW-2:0], sda_s2};
                            wr_valid_n = 1'b1;
                            bit_cnt_n  = '0;
                            phase_n    = 1'b0;
                            state_n    = WR_ACK;
                        end
                    end
                end

                RD_FETCH: begin
                    if (!phase) begin
                        if (scl_fall) begin
                            rd_req_n = 1'b1;
                            scl_n    = 1'b0;
                            phase_n  = 1'b1;
                        end
                    end else if (rd_valid_i) begin
                        // Accepting in the request cycle itself costs no extra stretch.
                        shreg_n   = rd_data_i;
                        sda_n     = rd_data_i[DW-1];
                        scl_n     = 1'b1;
                        bit_cnt_n = CW'(1);
                        phase_n   = 1'b0;
                        state_n   = RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == CW'(DW)) begin
                            sda_n     = 1'b1;
                            bit_cnt_n = '0;
                            state_n   = RD_ACK;
                        end else begin
                            shreg_n   = {shreg[DW-2:0], 1'b0};
                            sda_n     = shreg[DW-2];
                            bit_cnt_n = bit_cnt + CW'(1);
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        phase_n = 1'b0;
                        state_n = sda_s2 ? IGNORE : RD_FETCH;
                    end
                end

                default: begin
                    state_n = IDLE;
                    scl_n   = 1'b1;
                    sda_n   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_resp.sv
`timescale 1ns/1ps
// Bench for i2c_target_resp: a bit-banged bus controller drives the wire
// (wired-AND with the DUT drives), a byte source answers read requests, and
// scoreboard queues hold the bytes expected on each side.
module tb_i2c_target_resp;

    localparam int Q = 10;   // clk cycles between a line change and SCL edge
    localparam int H = 20;   // clk cycles of SCL high time

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_w, sda_w;
    logic       scl_o, sda_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o;
    logic [7:0] wr_data_o;
    logic       rd_valid_i = 1'b0;
    logic [7:0] rd_data_i = 8'h00;

    assign scl_w = scl_m & scl_o;
    assign sda_w = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_resp dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .scl_i      (scl_w),
        .sda_i      (sda_w),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .wr_valid_o (wr_valid_o),
        .wr_data_o  (wr_data_o),
        .rd_req_o   (rd_req_o),
        .rd_valid_i (rd_valid_i),
        .rd_data_i  (rd_data_i),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o)
    );

    int n_pass = 0;
    int n_total = 0;

    // Output monitor, sampled on the inactive edge.
    int         n_wrv = 0, n_start = 0, n_stop = 0, n_rdreq = 0;
    int         n_sda_low = 0, n_busy = 0, n_busy_drop = 0;
    int         scl_run = 0, max_scl_run = 0;
    logic [7:0] got_wr [64];
    logic       watch_busy = 1'b0;

    always @(negedge clk) begin
        if (wr_valid_o) begin
            got_wr[n_wrv[5:0]] <= wr_data_o;
            n_wrv <= n_wrv + 1;
        end
        if (start_o)  n_start <= n_start + 1;
        if (stop_o)   n_stop <= n_stop + 1;
        if (rd_req_o) n_rdreq <= n_rdreq + 1;
        if (!sda_o)   n_sda_low <= n_sda_low + 1;
        if (busy_o)   n_busy <= n_busy + 1;
        if (watch_busy && !busy_o) n_busy_drop <= n_busy_drop + 1;
        if (!scl_o) begin
            scl_run <= scl_run + 1;
            if (scl_run + 1 > max_scl_run) max_scl_run <= scl_run + 1;
        end else begin
            scl_run <= 0;
        end
    end

    // Read byte source: answers each request after rd_delay cycles.
    logic [7:0] rd_src [8];
    int         rd_idx = 0;
    int         rd_wp = 0;
    int         rd_delay = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rd_req_o) begin
                if (rd_delay > 0) repeat (rd_delay) @(negedge clk);
                rd_data_i  = rd_src[rd_idx[2:0]];
                rd_valid_i = 1'b1;
                rd_idx++;
                @(negedge clk);
                rd_valid_i = 1'b0;
            end
        end
    end

    logic [7:0] exp_wr [$];
    logic [7:0] exp_rd [$];
    int         wr_rp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_scl_high();
        for (int k = 0; k < 4000 && scl_w !== 1'b1; k++) @(negedge clk);
        if (scl_w !== 1'b1) begin
            n_total++;
            $display("FAIL scl_release: SCL still held low after 4000 cycles, expected release");
        end
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        wait_scl_high();
        repeat (H / 2) @(negedge clk);
        r = sda_w;
        repeat (H / 2) @(negedge clk);
        scl_m = 1'b0;
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        wait_scl_high();
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (H) @(negedge clk);
        scl_m = 1'b0;
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        wait_scl_high();
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    task automatic push_rd(input logic [7:0] v);
        rd_src[rd_wp[2:0]] = v;
        rd_wp++;
        exp_rd.push_back(v);
    endtask

    task automatic check_rd(input logic [7:0] got);
        logic [7:0] e;
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
        chk("rd_data", 32'(got), 32'(e));
    endtask

    // Pops one expected byte per received write byte, then requires none left.
    task automatic check_wr();
        logic [7:0] e;
        while (wr_rp < n_wrv) begin
            e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 8'hxx;
            chk("wr_data", 32'(got_wr[wr_rp[5:0]]), 32'(e));
            wr_rp++;
        end
        chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rnw;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_wrv;
        int         exp_rdreq;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] d [2];
        int b_wrv, b_rdreq, b_start, b_stop, b_sda, b_busy, b_drop;

        vecs[0] = '{7'h22, 1'b0, 2, 8'hA5, 8'h3C, 1'b1, 2, 0};
        vecs[1] = '{7'h22, 1'b1, 2, 8'h5A, 8'hC3, 1'b1, 0, 2};
        vecs[2] = '{7'h23, 1'b0, 1, 8'h77, 8'h00, 1'b0, 0, 0};
        vecs[3] = '{7'h22, 1'b0, 1, 8'h00, 8'h00, 1'b1, 1, 0};
        vecs[4] = '{7'h22, 1'b0, 1, 8'hFF, 8'h00, 1'b1, 1, 0};
        vecs[5] = '{7'h2A, 1'b1, 1, 8'h99, 8'h00, 1'b0, 0, 0};
        vecs[6] = '{7'h22, 1'b1, 1, 8'h81, 8'h00, 1'b1, 0, 1};

        // Reset state.
        repeat (5) @(negedge clk);
        chk("reset_lines", 32'({scl_o, sda_o}), 32'b11);
        chk("reset_pulses", 32'({wr_valid_o, rd_req_o, start_o, stop_o, busy_o}), 32'd0);
        chk("reset_wr_data", 32'(wr_data_o), 32'd0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk);

        // Table-driven transactions, each START .. STOP.
        for (int v = 0; v < 7; v++) begin
            b_wrv = n_wrv; b_rdreq = n_rdreq; b_start = n_start; b_stop = n_stop;
            b_sda = n_sda_low; b_busy = n_busy;
            d[0] = vecs[v].d0;
            d[1] = vecs[v].d1;
            for (int j = 0; j < vecs[v].nbytes; j++) begin
                if (vecs[v].exp_ack && !vecs[v].rnw) exp_wr.push_back(d[j]);
                if (vecs[v].exp_ack && vecs[v].rnw)  push_rd(d[j]);
            end
            bus_start();
            send_byte({vecs[v].addr, vecs[v].rnw}, ack);
            chk($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            if (!vecs[v].rnw) begin
                for (int j = 0; j < vecs[v].nbytes; j++) begin
                    send_byte(d[j], ack);
                    chk($sformatf("v%0d_data_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
                end
            end else if (vecs[v].exp_ack) begin
                for (int j = 0; j < vecs[v].nbytes; j++) begin
                    recv_byte(j == vecs[v].nbytes - 1, b);
                    check_rd(b);
                end
                // After the NACK the target must leave the bus alone.
                recv_byte(1'b1, b);
                chk($sformatf("v%0d_ignore_sda", v), 32'(b), 32'hFF);
            end
            bus_stop();
            chk($sformatf("v%0d_wr_valid", v), 32'(n_wrv - b_wrv), 32'(vecs[v].exp_wrv));
            chk($sformatf("v%0d_rd_req", v), 32'(n_rdreq - b_rdreq), 32'(vecs[v].exp_rdreq));
            chk($sformatf("v%0d_start", v), 32'(n_start - b_start), 32'd1);
            chk($sformatf("v%0d_stop", v), 32'(n_stop - b_stop), 32'd1);
            chk($sformatf("v%0d_sda_driven", v), 32'((n_sda_low - b_sda) > 0), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_busy_seen", v), 32'((n_busy - b_busy) > 0), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_busy_after_stop", v), 32'(busy_o), 32'd0);
            check_wr();
        end

        // Slow byte source: SCL stretched while waiting.
        rd_delay = 50;
        b_rdreq = n_rdreq;
        push_rd(8'h96);
        bus_start();
        send_byte({7'h22, 1'b1}, ack);
        chk("stretch_addr_ack", 32'(ack), 32'd1);
        recv_byte(1'b1, b);
        check_rd(b);
        bus_stop();
        chk("stretch_min", 32'(max_scl_run >= 50), 32'd1);
        chk("stretch_max", 32'(max_scl_run <= 53), 32'd1);
        chk("stretch_rd_req", 32'(n_rdreq - b_rdreq), 32'd1);
        rd_delay = 0;

        // Write then repeated START into a read.
        b_wrv = n_wrv; b_start = n_start; b_rdreq = n_rdreq; b_drop = n_busy_drop;
        exp_wr.push_back(8'h11);
        push_rd(8'h4E);
        bus_start();
        send_byte({7'h22, 1'b0}, ack);
        chk("rs_addr_w_ack", 32'(ack), 32'd1);
        watch_busy = 1'b1;
        send_byte(8'h11, ack);
        chk("rs_data_ack", 32'(ack), 32'd1);
        bus_start();
        send_byte({7'h22, 1'b1}, ack);
        chk("rs_addr_r_ack", 32'(ack), 32'd1);
        recv_byte(1'b1, b);
        check_rd(b);
        watch_busy = 1'b0;
        bus_stop();
        chk("rs_start_count", 32'(n_start - b_start), 32'd2);
        chk("rs_wr_valid", 32'(n_wrv - b_wrv), 32'd1);
        chk("rs_rd_req", 32'(n_rdreq - b_rdreq), 32'd1);
        chk("rs_busy_drop", 32'(n_busy_drop - b_drop), 32'd0);
        check_wr();

        // Reset in the middle of a write byte.
        b_wrv = n_wrv;
        bus_start();
        send_byte({7'h22, 1'b0}, ack);
        chk("rst_addr_ack", 32'(ack), 32'd1);
        for (int i = 7; i >= 4; i--) begin
            logic r;
            b = 8'hAB;
            bit_xfer(b[i], r);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_lines_released", 32'({scl_o, sda_o}), 32'b11);
        repeat (4) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (H) @(negedge clk);
        chk("rst_no_wr_valid", 32'(n_wrv - b_wrv), 32'd0);
        exp_wr.push_back(8'h5C);
        bus_start();
        send_byte({7'h22, 1'b0}, ack);
        chk("post_rst_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h5C, ack);
        chk("post_rst_data_ack", 32'(ack), 32'd1);
        bus_stop();
        chk("post_rst_wr_valid", 32'(n_wrv - b_wrv), 32'd1);
        check_wr();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_target_resp.md
I2C_TARGET_RESP -- requirements
Module: i2c_target_resp

Interface
REQ-001 SHALL have parameter I2C_ADDR_WIDTH, 7, target address width.
REQ-002 SHALL have parameter I2C_DATA_WIDTH, 8, bits per data byte.
REQ-003 SHALL have parameter TARGET_ADDR, 7'h22, address this block responds to.
REQ-004 SHALL have port clk_i  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port scl_i  in  1  I2C clock as seen on the wire.
REQ-007 SHALL have port sda_i  in  1  I2C data as seen on the wire.
REQ-008 SHALL have port scl_o  out  1  open-drain clock drive: 0 pulls low, 1 releases.
REQ-009 SHALL have port sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases.
REQ-010 SHALL have port wr_valid_o  out  1  one-cycle pulse when a write byte is received.
REQ-011 SHALL have port wr_data_o  out  I2C_DATA_WIDTH  received byte; valid with wr_valid_o.
REQ-012 SHALL have port rd_req_o  out  1  one-cycle pulse requesting the next read byte.
REQ-013 SHALL have port rd_valid_i  in  1  read byte on rd_data_i is valid.
REQ-014 SHALL have port rd_data_i  in  I2C_DATA_WIDTH  byte to return to the controller.
REQ-015 SHALL have ports start_o and stop_o  out  1 each  one-cycle pulses on START and STOP.
REQ-016 SHALL have port busy_o  out  1  high from an address match until STOP.

Function
REQ-017 SHALL pass scl_i and sda_i through 2-flop synchronizers plus one history flop; edges are detected on synchronized values only.
REQ-018 SHALL detect START as sda falling while scl high and STOP as sda rising while scl high; start_o/stop_o SHALL pulse 3 clk_i cycles after the pin event.
REQ-019 SHALL use states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_FETCH, RD_DATA, RD_ACK, IGNORE.
REQ-020 SHALL sample bits MSB first on synchronized SCL rising edges; sda_o SHALL change only on synchronized SCL falling edges.
REQ-021 START in any state (including repeated START) SHALL clear the bit counter and go to ADDR.
REQ-022 STOP in any state SHALL go to IDLE, release both lines, and clear busy_o.
REQ-023 ADDR: after 7 address bits plus R/W bit, match -> ADDR_ACK with busy_o=1; mismatch -> IGNORE, sda_o stays 1.
REQ-024 ADDR_ACK/WR_ACK: drive sda_o=0 from the falling edge after bit 8 until the next falling edge, then release.
REQ-025 ADDR_ACK exit: R/W=0 -> WR_DATA; R/W=1 -> RD_FETCH.
REQ-026 WR_DATA: on the 8th rising edge, latch byte into wr_data_o and pulse wr_valid_o for 1 cycle, then go to WR_ACK; every write byte is ACKed.
REQ-027 RD_FETCH: on the SCL falling edge, pulse rd_req_o once and hold scl_o=0 (clock stretch) until rd_valid_i=1.
REQ-028 If rd_valid_i=1 in the same cycle as rd_req_o, the data SHALL be accepted with no stretch cycle beyond that one.
REQ-029 On acceptance, load rd_data_i into the shift register, drive its MSB on sda_o, release scl_o, and go to RD_DATA.
REQ-030 RD_DATA: shift out the next bit on each falling edge; after bit 8, release sda_o and go to RD_ACK.
REQ-031 RD_ACK: sample on the rising edge; ACK (0) -> RD_FETCH; NACK (1) -> IGNORE until STOP or START.
REQ-032 IGNORE SHALL drive neither line and emit no wr_valid_o or rd_req_o.
REQ-033 A STOP or START arriving mid-byte SHALL discard the partial byte with no wr_valid_o pulse.

Reset
REQ-034 While rst_i=1: state IDLE, scl_o=1, sda_o=1, wr_valid_o=0, wr_data_o=0, rd_req_o=0, start_o=0, stop_o=0, busy_o=0, counters and shift register 0.
REQ-035 Reset mid-transfer SHALL release both lines on the first clock with rst_i=1; the block SHALL wait for a new START after reset.

Verification
REQ-036 Write addr 0x22 W, bytes 0xA5, 0x3C, STOP -> three ACK lows on SDA; wr_valid_o pulses twice with 0xA5 then 0x3C; stop_o pulses once.
REQ-037 Read addr 0x22 R, rd_data_i 0x5A then 0xC3, controller ACKs then NACKs -> SDA carries 0x5A, 0xC3 MSB first; exactly 2 rd_req_o pulses; IGNORE after the NACK.
REQ-038 Address 0x23 W plus one byte -> SDA never driven low; no wr_valid_o pulse; busy_o stays 0.
REQ-039 Read with rd_valid_i delayed 50 cycles after rd_req_o -> scl_o held 0 for at least 50 cycles; byte correct afterwards.
REQ-040 Write 0x22 byte 0x11, repeated START, read 0x22 one byte -> wr_valid_o pulse (0x11), start_o pulses twice, read byte correct, busy_o high throughout.
REQ-041 rst_i asserted at write bit 4 -> scl_o=sda_o=1 on the next clock; no wr_valid_o pulse; the next full write is received correctly.
